multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 82 ++++++++
 rtl/alu_decoder.sv | 38 +++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// Module   : multicycle_controller_pkg
// Purpose  : Shared FSM states, opcodes and control-field encodings for the
//            multicycle RISC-V controller. TRAP exists only with
//            MC_CTRL_ILLEGAL_TRAP_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , S_TRAP   = 4'd11
`endif
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_decode(input logic [6:0] op_i);
    case (op_i)
      OP_LOAD, OP_ITYPE: imm_decode = IMM_I;
      OP_STORE:          imm_decode = IMM_S;
      OP_BRANCH:         imm_decode = IMM_B;
      OP_JAL:            imm_decode = IMM_J;
      default:           imm_decode = IMM_I;
    endcase
  endfunction

  function automatic logic is_known_op(input logic [6:0] op_i);
    case (op_i)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: is_known_op = 1'b1;
      default: is_known_op = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps the FSM's aluop request plus funct fields to alucontrol.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op5=1) can request subtract; addi with bit 30 set stays add.
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multicycle RISC-V control FSM with memory handshake. Define
//            MC_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes (adds illegal).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol,
  output logic       instr_done
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  , output logic     illegal
`endif
);

  state_e     state_q, state_d;
  logic       pcupdate;
  logic       branch;
  logic       mem_wr;
  logic       ir_wr;
  logic       reg_wr;
  logic [1:0] aluop;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (state_d == S_TRAP);
  assign illegal   = illegal_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Outputs are a function of the held state; FETCH and the memory states
  // also look at mem_ready so the handshake completes in the same cycle.
  always_comb begin
    pcupdate   = 1'b0;
    branch     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = RES_ALUOUT;
    alusrca    = SRCA_PC;
    alusrcb    = SRCB_RD2;
    aluop      = ALUOP_ADD;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb   = SRCB_FOUR;
        resultsrc = RES_ALURESULT;
        ir_wr     = mem_ready;
        pcupdate  = mem_ready;
      end
      S_DECODE: begin
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
        instr_done = ~is_known_op(op);
`endif
      end
      S_MEMADR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        mem_wr     = 1'b1;
        instr_done = mem_ready;
      end
      S_MEMWB: begin
        resultsrc  = RES_DATA;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_RD2;
        aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alusrca = SRCA_RD1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alusrca    = SRCA_RD1;
        alusrcb    = SRCB_RD2;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alusrca  = SRCA_OLDPC;
        alusrcb  = SRCB_FOUR;
        pcupdate = 1'b1;
      end
      default: begin
        instr_done = 1'b0;
      end
    endcase
  end

  // Reset gates the write enables directly so an aborted access stops at once.
  assign pcwrite  = reset & (pcupdate | (branch & zero));
  assign memwrite = reset & mem_wr;
  assign irwrite  = reset & ir_wr;
  assign regwrite = reset & reg_wr;
  assign immsrc   = imm_decode(op);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed self-checking bench for multicycle_controller; honours
//            MC_CTRL_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, instr_done;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [16:0] exp_vec = '0;
  logic        exp_ill = 1'b0;
  bit          exp_valid = 1'b0;
  logic [16:0] trace[$];
  logic [16:0] act;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .alucontrol (alucontrol),
    .instr_done (instr_done)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , .illegal  (illegal)
`endif
  );

  // Bit layout: pcw adr mw irw rw res[2] srca[2] srcb[2] imm[2] alu[3] done
  assign act = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                alusrca, alusrcb, immsrc, alucontrol, instr_done};

  always @(negedge clk) begin
    cyc++;
    if (exp_valid) begin
      trace.push_back(act);
      checks++;
      if (act !== exp_vec) begin
        errors++;
        $display("FAIL outputs cycle %0d: got %05h expected %05h", cyc, act, exp_vec);
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      checks++;
      if (illegal !== exp_ill) begin
        errors++;
        $display("FAIL illegal cycle %0d: got %b expected %b", cyc, illegal, exp_ill);
      end
`endif
    end
  end

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0000011 || o == 7'b0010011) return 2'b00;
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic b5);
    case (f3)
      3'b000:  return (o[5] && b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic nop_done(input logic [6:0] o);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    return 1'b0;
`else
    return !(o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
             o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
`endif
  endfunction

  function automatic logic [16:0] mk(input logic [6:0] o, input logic pcw, input logic adr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic [1:0] res, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu, input logic done);
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm_of(o), alu, done};
  endfunction

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step(input logic r, input logic [16:0] e, input logic ill);
    mem_ready = r;
    exp_vec   = e;
    exp_ill   = ill;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Expected per-cycle outputs of one instruction, built from its class.
  task automatic run_instr(input logic [31:0] ins, input logic z, input int fw, input int mw);
    logic [6:0] o;
    logic [16:0] wb;
    o = ins[6:0];
    op = o; funct3 = ins[14:12]; funct7b5 = ins[30]; zero = z;
    trace.delete();
    wb = mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
    for (int i = 0; i < fw; i++)
      step(1'b0, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0), 1'b0);
    step(1'b1, mk(o, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0), 1'b0);
    step(1'b1, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, nop_done(o)), 1'b0);
    if (o == 7'b0000011 || o == 7'b0100011) begin
      step(1'b1, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0), 1'b0);
      for (int i = 0; i < mw; i++)
        step(1'b0, mk(o, 1'b0, 1'b1, o[5], 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 1'b0);
      if (o[5]) begin
        step(1'b1, mk(o, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1), 1'b0);
      end else begin
        step(1'b1, mk(o, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 1'b0);
        step(1'b1, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1), 1'b0);
      end
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      step(1'b1, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, o[5] ? 2'b00 : 2'b01,
                    alu_of(o, ins[14:12], ins[30]), 1'b0), 1'b0);
      step(1'b1, wb, 1'b0);
    end else if (o == 7'b1100011) begin
      step(1'b1, mk(o, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b1), 1'b0);
    end else if (o == 7'b1101111) begin
      step(1'b1, mk(o, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0), 1'b0);
      step(1'b1, wb, 1'b0);
    end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 4; i++)
        step(1'b1, mk(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 1'b1);
`endif
    end
    exp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
    @(posedge clk);
    #1;
    lit("rst_irwrite",  32'(irwrite),  32'd0);
    lit("rst_pcwrite",  32'(pcwrite),  32'd0);
    lit("rst_regwrite", 32'(regwrite), 32'd0);
    lit("rst_memwrite", 32'(memwrite), 32'd0);
    lit("rst_fetch_srcb", 32'(alusrcb), 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(32'hFF718393, 1'b0, 0, 0);
    lit("addi_len", 32'(trace.size()), 32'd4);
    lit("addi_alu", 32'(trace[2][3:1]), 32'd0);
    lit("addi_rw_early", 32'({trace[0][12], trace[1][12], trace[2][12]}), 32'd0);
    lit("addi_rw_wb", 32'(trace[3][12]), 32'd1);
    lit("addi_done", 32'({trace[0][0], trace[1][0], trace[2][0], trace[3][0]}), 32'd1);

    run_instr(32'h0002A303, 1'b0, 0, 3);
    lit("lw_len", 32'(trace.size()), 32'd8);
    lit("lw_hold_rw", 32'({trace[3][12], trace[4][12], trace[5][12], trace[6][12]}), 32'd0);
    lit("lw_wb_rw", 32'(trace[7][12]), 32'd1);

    run_instr(32'h0062A223, 1'b0, 2, 1);
    run_instr(32'h00628463, 1'b1, 0, 0);
    lit("beq_taken_pcw", 32'(trace[2][16]), 32'd1);
    run_instr(32'h00628463, 1'b0, 0, 0);
    lit("beq_nt_pcw", 32'({trace[1][16], trace[2][16]}), 32'd0);
    lit("beq_fetch_pcw", 32'(trace[0][16]), 32'd1);

    run_instr(32'h40628333, 1'b0, 0, 0);
    lit("sub_alu", 32'(trace[2][3:1]), 32'd1);
    run_instr(32'h0062F333, 1'b0, 0, 0);
    run_instr(32'h0062E333, 1'b0, 0, 0);
    run_instr(32'h0062A333, 1'b0, 1, 0);
    lit("slt_alu", 32'(trace[3][3:1]), 32'd5);
    run_instr(32'h00629333, 1'b0, 0, 0);
    run_instr(32'h0FF2F313, 1'b0, 0, 0);
    run_instr(32'h0012A313, 1'b0, 0, 0);
    run_instr(32'h008000EF, 1'b0, 0, 0);

    run_instr(32'h00000000, 1'b0, 0, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    lit("trap_len", 32'(trace.size()), 32'd6);
    #1;
    reset = 1'b0;
    #1;
    lit("trap_ill_rst", 32'(illegal), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
`else
    lit("nop_len", 32'(trace.size()), 32'd2);
    lit("nop_done", 32'(trace[1][0]), 32'd1);
`endif
    run_instr(32'h00628463, 1'b1, 0, 0);

    // Abort a store while it waits on memory.
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    step(1'b1, mk(op, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0), 1'b0);
    step(1'b1, mk(op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0), 1'b0);
    step(1'b1, mk(op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0), 1'b0);
    step(1'b0, mk(op, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 1'b0);
    exp_valid = 1'b0;
    mem_ready = 1'b0;
    #1;
    lit("sw_memwrite_before", 32'(memwrite), 32'd1);
    reset = 1'b0;
    #1;
    lit("sw_memwrite_abort", 32'(memwrite), 32'd0);
    lit("sw_adrsrc_abort", 32'(adrsrc), 32'd0);
    mem_ready = 1'b1;
    #1;
    lit("sw_irwrite_abort", 32'(irwrite), 32'd0);
    lit("sw_pcwrite_abort", 32'(pcwrite), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr(32'hFF718393, 1'b0, 0, 0);
    lit("post_rst_len", 32'(trace.size()), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
